// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and data_memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, MemWrite, MemRead, busy
  );

  // Requester / memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, MemWrite, MemRead, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-ported data memory.
// Port 0 = load/store unit, port 1 = debug/loader.
//
// state | meaning
// IDLE  | no transaction; pick a winner among pending requests
// ISSUE | first memory cycle: write strobe, or first read cycle
// WAIT  | remaining read-latency cycles, address held
// DONE  | one-cycle ack to the winner
module dmem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Latency is at most 4, so 3 bits covers every counter value with headroom.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t            state;
  logic              lastGnt;
  logic [CNT_W-1:0]  cnt;
  logic              selQ;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;

  logic              m0Ack;
  logic              m1Ack;
  logic [DATA_W-1:0] m0Rdata;
  logic [DATA_W-1:0] m1Rdata;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memWrite;
  logic              memRead;
  logic              busyQ;

  logic              anyReq;
  logic              winner;
  logic              winWe;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winWdata;

  // Round-robin pick: on a tie the port that did not win last time goes first.
  always_comb begin
    anyReq = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      winner = ~lastGnt;
    end else begin
      winner = bus.m1_req;
    end
    winWe    = winner ? bus.m1_we    : bus.m0_we;
    winAddr  = winner ? bus.m1_addr  : bus.m0_addr;
    winWdata = winner ? bus.m1_wdata : bus.m0_wdata;
  end

  // Sequencer FSM; every output is a register so strobes are glitch-free and
  // drop together with the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lastGnt  <= 1'b1;
      cnt      <= '0;
      selQ     <= 1'b0;
      weQ      <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      m0Ack    <= 1'b0;
      m1Ack    <= 1'b0;
      m0Rdata  <= '0;
      m1Rdata  <= '0;
      memAddr  <= '0;
      memWdata <= '0;
      memWrite <= 1'b0;
      memRead  <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      m0Ack <= 1'b0;
      m1Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            selQ     <= winner;
            lastGnt  <= winner;
            weQ      <= winWe;
            addrQ    <= winAddr;
            wdataQ   <= winWdata;
            memAddr  <= winAddr;
            memWdata <= winWdata;
            memWrite <= winWe;
            memRead  <= ~winWe;
            busyQ    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (weQ) begin
            memWrite <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            m0Ack    <= ~selQ;
            m1Ack    <= selQ;
            state    <= DONE;
          end else begin
            cnt <= CNT_W'(1);
            if (MEM_LAT == 1) begin
              if (selQ) m1Rdata <= bus.mem_rdata;
              else      m0Rdata <= bus.mem_rdata;
              memRead  <= 1'b0;
              memAddr  <= '0;
              memWdata <= '0;
              m0Ack    <= ~selQ;
              m1Ack    <= selQ;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            if (selQ) m1Rdata <= bus.mem_rdata;
            else      m0Rdata <= bus.mem_rdata;
            memRead  <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            m0Ack    <= ~selQ;
            m1Ack    <= selQ;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          busyQ <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and write data are re-driven from the latched copies above;
  // addrQ/wdataQ keep the granted request immune to later requester changes.
  assign bus.m0_ack    = m0Ack;
  assign bus.m1_ack    = m1Ack;
  assign bus.m0_rdata  = m0Rdata;
  assign bus.m1_rdata  = m1Rdata;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.MemWrite  = memWrite;
  assign bus.MemRead   = memRead;
  assign bus.busy      = busyQ;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory. It shares the memory between the pipeline load/store unit (port 0) and the debug/loader port (port 1). Each request is latched and run as a fixed-length memory transaction, and completion is returned with a one-cycle ack. It sits between the MEM stage and data_memory and is the only block that drives the memory's address, write data and MemWrite/MemRead strobes.

## Interface
- ADDR_W, 5, memory word-address width
- DATA_W, 32, data width
- MEM_LAT, 1, read latency in cycles: cycles MemRead is held before mem_rdata is captured; legal range 1..4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  request, level; held until the matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read; valid while req is high
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  last read result for that port; held until that port's next read completes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - If any req is high, select a winner.
  - Latch the winner's index, we, addr and wdata.
  - Go to ISSUE.
- Arbitration is round-robin, driven by register last_gnt.
  - Single requester: that requester wins.
  - Both requesting: the port that is not last_gnt wins.
  - last_gnt updates on every grant.
  - last_gnt resets to 1, so port 0 wins the first tie.
- ISSUE, latched write:
  - MemWrite=1 for exactly this cycle.
  - mem_addr and mem_wdata carry the latched values.
  - Next state is DONE.
- ISSUE, latched read:
  - MemRead=1.
  - Load the cycle counter with 1.
  - If MEM_LAT==1, capture mem_rdata into the winner's rdata register at this edge and go to DONE; otherwise go to WAIT.
- WAIT (reads only):
  - MemRead=1 and mem_addr is held.
  - The counter increments each cycle.
  - When counter==MEM_LAT-1, capture mem_rdata at this edge and go to DONE.
- DONE:
  - Winner's ack=1 for this cycle only.
  - Next state is IDLE.
- Requesters deassert req the cycle after ack. A req still high in the following IDLE is a new request.
- Memory-side outputs are decoded from state and latched registers. Outside ISSUE/WAIT: mem_addr=0, mem_wdata=0, MemWrite=0, MemRead=0.
- Changes on a granted port's inputs after the grant have no effect on the running transaction.
- The losing requester's req stays pending. It is granted in the next IDLE, giving at most one transaction of wait.
- The non-winner's rdata register is never modified.

## Timing
- The cycle in which req is sampled in IDLE is cycle 0.
- Write: MemWrite in cycle 1, ack in cycle 2.
- Read: MemRead in cycles 1..MEM_LAT, rdata valid and ack in cycle MEM_LAT+1.
- Back-to-back: minimum period per transaction is 3 cycles for a write and MEM_LAT+2 for a read, because IDLE always takes one cycle.
- Reset values: state=IDLE, last_gnt=1, counter=0, all acks=0, m0_rdata=m1_rdata=0, all mem_* outputs and strobes=0, busy=0.
- rst asserted mid-transaction:
  - The FSM returns to IDLE immediately (asynchronously).
  - MemWrite/MemRead drop in the same cycle.
  - No ack is issued and the aborted read's rdata is not updated.
  - After rst deasserts, the first grant is decided normally.
- Simultaneous req rising on both ports in the same cycle: resolved by last_gnt as above. Never a double ack, never both strobes high.

## Test plan
- Reset then write: m0 write addr=5 data=0xDEADBEEF at cycle 0 -> MemWrite=1, mem_addr=5 in cycle 1; m0_ack in cycle 2; busy high cycles 1-2.
- Read with MEM_LAT=3: memory preloaded addr=7 = 0x12345678, m1 read addr 7 -> MemRead cycles 1-3; m1_ack and m1_rdata=0x12345678 in cycle 4; m0_rdata stays 0.
- Contention: m0 and m1 request writes in the same cycle after reset -> m0 granted first, m1 granted in the next IDLE. With both held continuously, grants alternate m0, m1, m0, m1.
- Input change after grant: m0 read addr=3, addr changed to 9 during WAIT -> mem_addr stays 3 and m0_rdata holds mem[3].
- Reset mid-read: rst asserted during WAIT -> strobes go to 0 the same cycle, no ack, rdata unchanged, state IDLE after release.
- Held req: requester keeps req high after ack -> treated as a new request in the next IDLE, with a second ack 3 cycles later for a write.
